dest_hazard_unit: RTL and testbench
===================================

# dest_hazard_unit

Consumer end of the destination-register path in the pipelined MIPS core. It takes the ID-stage write-register number (rt/rd choice already made by the ID decode) and carries it, with write-enable and load flag, down an internal EX/MEM/WB shadow pipeline. It compares each new ID instruction's source registers against the in-flight destinations to produce forwarding selects, load-use stalls, and the writeback register address. It sits beside the ID stage and feeds the ID operand muxes, the PC/IF-ID enables and the register-file write port.

## Interface
Parameters:
- `REG_W`, 5: register-number width.
- `CNT_W`, 16: stall-counter width.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: core clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `id_rs` in REG_W: ID source register A (Instr[25:21]).
- `id_rt` in REG_W: ID source register B (Instr[20:16]).
- `id_use_rs` in 1: ID instruction reads rs.
- `id_use_rt` in 1: ID instruction reads rt.
- `id_dest` in REG_W: ID write-register number (rt or rd, already selected).
- `id_wreg` in 1: ID instruction writes the register file.
- `id_m2reg` in 1: ID instruction is a load.
- `flush` in 1: squash the ID instruction (taken branch/jump); it enters EX as a bubble.
- `stall` out 1: load-use stall; holds PC and IF/ID.
- `fwda` out 2: operand A select: 00 regfile, 01 EX ALU result, 10 MEM ALU result, 11 MEM load data.
- `fwdb` out 2: operand B select, same encoding.
- `wb_dest` out REG_W: writeback register number.
- `wb_wreg` out 1: writeback enable.
- `stall_count` out CNT_W: saturating count of stall cycles.

## Operation
- Shadow slots EX, MEM and WB each hold {valid, wreg, m2reg, dest}. A slot's entry is "live" when valid=1, wreg=1 and dest≠0.
- Each edge: WB←MEM, MEM←EX, and EX←ID entry, except that EX←bubble (all zero) when `stall` or `flush` is high.
- Per operand X ∈ {rs, rt}, used when `id_use_X`=1:
  - EX live and dest==X and EX.m2reg=1: raise `stall`.
  - Otherwise EX live and dest==X, with EX.m2reg=0: select 01.
  - Otherwise MEM live and dest==X: select 10 if MEM.m2reg=0, 11 if MEM.m2reg=1.
  - Otherwise: select 00.
  - EX has priority over MEM.
- The WB stage is never forwarded. The register file writes in the first half of the cycle and reads in the second.
- Register 0 never matches, and an unused operand never causes a stall. An unused operand's select is 00.
- `stall` is the OR over both operands. `fwda` and `fwdb` remain valid during a stall.
- `flush` and `stall` together: the EX bubble is inserted once, and `stall` still holds IF/ID.
- `stall_count` increments on each cycle with `stall`=1 and saturates at all ones.
- `wb_dest`/`wb_wreg` are taken directly from the WB slot. `wb_wreg` = valid & wreg.

## Timing
- `stall`, `fwda` and `fwdb` are combinational from the ID inputs and the EX/MEM slots, with zero latency.
- An ID instruction appears in `wb_dest` exactly 3 edges after it is accepted.
- Load-use costs exactly one stall cycle. On the next cycle the load sits in MEM, so the select is 11 and `stall` is 0.
- Reset behaviour:
  - All slots are cleared to bubbles.
  - `stall`=0, `fwda`=`fwdb`=00.
  - `wb_dest`=0, `wb_wreg`=0, `stall_count`=0.
- Reset mid-operation discards all in-flight entries on that edge. No forwarding is reported on the following cycle.
- `rst` has priority over `flush` and `stall`.

## Structure
- Shared package `mips_pkg` holds:
  - Forwarding-select constants FWD_REG=2'b00, FWD_EXALU=2'b01, FWD_MEMALU=2'b10, FWD_MEMLD=2'b11.
  - The slot typedef {valid, wreg, m2reg, dest[4:0]}.
  - REG_W.
- One sub-module, `fwd_select`, is instantiated twice (rs and rt). Its inputs are the source register, the use flag and the EX/MEM slots; its outputs are the 2-bit select and a stall request.
- The slot pipeline and the counter live in the top module.

## Test plan
- Back-to-back ALU ops `add $3,$1,$2` then `sub $4,$3,$1`: on the second, `fwda`=01, `fwdb`=00, `stall`=0.
- ALU-to-one-gap ALU: `add $5,…`, `nop`, `or $6,$5,$5` → `fwda`=`fwdb`=10.
- Load-use: `lw $7,0($1)` then `add $8,$7,$2` → `stall`=1 for one cycle, then `fwda`=11, `stall`=0; `stall_count` goes from 0 to 1; `wb_dest`=7 three edges after the `lw` is accepted.
- Register 0 and unused operands:
  - `add $0,…` followed by a reader of $0 → `fwda`=00.
  - A `lui` (uses rs=0) after a load to $9 with rt=9 and `id_use_rt`=0 → no stall.
- Flush: assert `flush` with `id_dest`=10, `id_wreg`=1, then issue a reader of $10 → select 00; `wb_wreg` stays 0 three cycles later.
- Counter and reset:
  - Force 65,536 stall cycles → `stall_count` holds 0xFFFF.
  - Assert `rst` with live EX/MEM slots → next cycle all outputs are 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types for the destination-register shadow pipeline: slot layout,
// forwarding-select encodings and the register-number width.
package mips_pkg;

  localparam int REG_W = 5;

  localparam logic [1:0] FWD_REG    = 2'b00;
  localparam logic [1:0] FWD_EXALU  = 2'b01;
  localparam logic [1:0] FWD_MEMALU = 2'b10;
  localparam logic [1:0] FWD_MEMLD  = 2'b11;

  typedef struct packed {
    logic             valid;
    logic             wreg;
    logic             m2reg;
    logic [REG_W-1:0] dest;
  } slot_t;

  // A slot produces a forwardable value for r only if it really writes a nonzero register.
  function automatic logic slot_hits(slot_t s, logic [REG_W-1:0] r);
    return s.valid && s.wreg && (s.dest != '0) && (s.dest == r);
  endfunction

endpackage

// File: rtl/dest_hazard_unit_fwd_select.sv
// Per-operand forwarding select and load-use stall request.
// Latency: combinational. Backpressure: none; stall_req is the only hold signal.
// An EX load hit stalls with the select left at FWD_REG; EX outranks MEM.
module fwd_select
  import mips_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic             use_src,
  input  slot_t            ex,
  input  slot_t            mem,
  output logic [1:0]       sel,
  output logic             stall_req
);

  always_comb begin
    sel       = FWD_REG;
    stall_req = 1'b0;
    if (use_src) begin
      if (slot_hits(ex, src)) begin
        if (ex.m2reg) stall_req = 1'b1;
        else          sel       = FWD_EXALU;
      end else if (slot_hits(mem, src)) begin
        sel = mem.m2reg ? FWD_MEMLD : FWD_MEMALU;
      end
    end
  end

endmodule

// File: rtl/dest_hazard_unit.sv
// EX/MEM/WB shadow of the ID destination: forwarding selects, load-use stall, WB address.
// Latency: selects/stall combinational; wb_dest 3 edges after accept. Backpressure: stall holds PC and IF/ID.
// A stalled or flushed ID instruction enters EX as a bubble.
module dest_hazard_unit #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_wreg,
  input  logic             id_m2reg,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fwda,
  output logic [1:0]       fwdb,
  output logic [REG_W-1:0] wb_dest,
  output logic             wb_wreg,
  output logic [CNT_W-1:0] stall_count
);
  import mips_pkg::*;

  slot_t ex_q, mem_q, wb_q;
  slot_t id_slot;
  logic  stall_a, stall_b;

  always_comb begin
    id_slot       = '0;
    id_slot.valid = 1'b1;
    id_slot.wreg  = id_wreg;
    id_slot.m2reg = id_m2reg;
    id_slot.dest  = id_dest;
  end

  fwd_select u_fwd_rs (
    .src       (id_rs),
    .use_src   (id_use_rs),
    .ex        (ex_q),
    .mem       (mem_q),
    .sel       (fwda),
    .stall_req (stall_a)
  );

  fwd_select u_fwd_rt (
    .src       (id_rt),
    .use_src   (id_use_rt),
    .ex        (ex_q),
    .mem       (mem_q),
    .sel       (fwdb),
    .stall_req (stall_b)
  );

  assign stall = stall_a | stall_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      ex_q  <= (stall || flush) ? '0 : id_slot;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                              stall_count <= '0;
    else if (stall && (stall_count != '1)) stall_count <= stall_count + 1'b1;
  end

  assign wb_dest = wb_q.dest;
  assign wb_wreg = wb_q.valid & wb_q.wreg;

endmodule

// File: tb/tb_dest_hazard_unit.sv
// Directed MIPS hazard scenarios plus random traffic against a history-based reference model.
module tb_dest_hazard_unit;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, id_dest;
  logic       id_use_rs, id_use_rt, id_wreg, id_m2reg, flush;
  logic       stall;
  logic [1:0] fwda, fwdb;
  logic [4:0] wb_dest;
  logic       wb_wreg;
  logic [CNT_W-1:0] stall_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dest_hazard_unit #(.REG_W(5), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_dest(id_dest), .id_wreg(id_wreg), .id_m2reg(id_m2reg), .flush(flush),
    .stall(stall), .fwda(fwda), .fwdb(fwdb),
    .wb_dest(wb_dest), .wb_wreg(wb_wreg), .stall_count(stall_count)
  );

  // Reference model: list of instructions that entered EX, newest last.
  typedef struct {
    bit v;
    bit w;
    bit m;
    int d;
  } ent_t;

  ent_t hist[$];
  int   m_cnt;

  function automatic ent_t ago(int k);
    ent_t e;
    e = '{v: 0, w: 0, m: 0, d: 0};
    if (hist.size() >= k) e = hist[hist.size() - k];
    return e;
  endfunction

  // Youngest in-flight producer of src wins; a load one instruction ahead forces a stall.
  task automatic model_fwd(input int src, input bit used, output int sel, output bit st);
    ent_t e;
    sel = 0;
    st  = 0;
    if (used && src != 0) begin
      for (int age = 1; age <= 2; age++) begin
        e = ago(age);
        if (e.v && e.w && e.d == src) begin
          if (age == 1) begin
            if (e.m) st = 1;
            else     sel = 1;
          end else begin
            sel = e.m ? 3 : 2;
          end
          break;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int rs, input int rt, input bit urs, input bit urt,
                       input int dest, input bit wr, input bit ld, input bit fl);
    rst       = 1'b0;
    id_rs     = 5'(rs);
    id_rt     = 5'(rt);
    id_use_rs = urs;
    id_use_rt = urt;
    id_dest   = 5'(dest);
    id_wreg   = wr;
    id_m2reg  = ld;
    flush     = fl;
  endtask

  // Compare all outputs to the model, then clock once and advance the model.
  task automatic step();
    int sa, sb;
    bit ta, tb;
    ent_t w;
    ent_t n;
    #1;
    model_fwd(int'(id_rs), id_use_rs, sa, ta);
    model_fwd(int'(id_rt), id_use_rt, sb, tb);
    w = ago(3);
    chk("stall", 32'(stall), 32'(ta | tb));
    chk("fwda", 32'(fwda), 32'(sa));
    chk("fwdb", 32'(fwdb), 32'(sb));
    chk("wb_dest", 32'(wb_dest), 32'(w.d));
    chk("wb_wreg", 32'(wb_wreg), 32'(w.v && w.w));
    chk("stall_count", 32'(stall_count), 32'(m_cnt));
    @(posedge clk);
    if (rst) begin
      hist.delete();
      m_cnt = 0;
    end else begin
      if (ta || tb || flush) n = '{v: 0, w: 0, m: 0, d: 0};
      else n = '{v: 1, w: id_wreg, m: id_m2reg, d: int'(id_dest)};
      hist.push_back(n);
      if (hist.size() > 3) void'(hist.pop_front());
      if ((ta || tb) && m_cnt < CNT_MAX) m_cnt++;
    end
    #1;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      step();
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    hist.delete();
    m_cnt = 0;
    chk("rst_stall", 32'(stall), 0);
    chk("rst_fwda", 32'(fwda), 0);
    chk("rst_fwdb", 32'(fwdb), 0);
    chk("rst_wb_dest", 32'(wb_dest), 0);
    chk("rst_wb_wreg", 32'(wb_wreg), 0);
    chk("rst_count", 32'(stall_count), 0);
    nops(3);

    // add $3,$1,$2 ; sub $4,$3,$1
    drive(1, 2, 1, 1, 3, 1, 0, 0); step();
    drive(3, 1, 1, 1, 4, 1, 0, 0); #1;
    chk("b2b_fwda", 32'(fwda), 1);
    chk("b2b_fwdb", 32'(fwdb), 0);
    chk("b2b_stall", 32'(stall), 0);
    step();
    nops(3);

    // add $5 ; nop ; or $6,$5,$5
    drive(1, 2, 1, 1, 5, 1, 0, 0); step();
    nops(1);
    drive(5, 5, 1, 1, 6, 1, 0, 0); #1;
    chk("gap_fwda", 32'(fwda), 2);
    chk("gap_fwdb", 32'(fwdb), 2);
    step();
    nops(3);

    // lw $7,0($1) ; add $8,$7,$2 (held one cycle by the stall)
    drive(1, 7, 1, 0, 7, 1, 1, 0); step();
    drive(7, 2, 1, 1, 8, 1, 0, 0); #1;
    chk("lu_stall1", 32'(stall), 1);
    chk("lu_cnt0", 32'(stall_count), 0);
    step();
    #1;
    chk("lu_stall2", 32'(stall), 0);
    chk("lu_fwda", 32'(fwda), 3);
    chk("lu_cnt1", 32'(stall_count), 1);
    step();
    chk("lu_wb_dest", 32'(wb_dest), 7);
    chk("lu_wb_wreg", 32'(wb_wreg), 1);
    nops(3);

    // add $0 ; reader of $0
    drive(1, 2, 1, 1, 0, 1, 0, 0); step();
    drive(0, 1, 1, 1, 11, 1, 0, 0); #1;
    chk("r0_fwda", 32'(fwda), 0);
    step();
    nops(3);

    // lw $9 ; lui with rt=9 unused
    drive(1, 9, 1, 0, 9, 1, 1, 0); step();
    drive(0, 9, 1, 0, 9, 1, 0, 0); #1;
    chk("lui_stall", 32'(stall), 0);
    chk("lui_fwdb", 32'(fwdb), 0);
    step();
    nops(3);

    // flushed writer of $10 ; reader of $10
    drive(1, 2, 1, 1, 10, 1, 0, 1); step();
    drive(10, 10, 1, 1, 12, 0, 0, 0); #1;
    chk("fl_fwda", 32'(fwda), 0);
    chk("fl_fwdb", 32'(fwdb), 0);
    step();
    drive(10, 10, 1, 1, 13, 0, 0, 0); step();
    chk("fl_wb_wreg", 32'(wb_wreg), 0);
    nops(3);

    // repeated self-dependent loads: stall every other cycle until saturation
    for (int i = 0; i < 2 * CNT_MAX + 20; i++) begin
      drive(7, 0, 1, 0, 7, 1, 1, 0);
      step();
    end
    chk("sat_count", 32'(stall_count), 32'(CNT_MAX));

    // reset with live EX/MEM
    drive(1, 2, 1, 1, 14, 1, 0, 0); step();
    drive(1, 2, 1, 1, 15, 1, 1, 0); step();
    drive(14, 15, 1, 1, 16, 1, 0, 0);
    rst = 1'b1;
    step();
    drive(14, 15, 1, 1, 16, 1, 0, 0); #1;
    chk("rr_stall", 32'(stall), 0);
    chk("rr_fwda", 32'(fwda), 0);
    chk("rr_fwdb", 32'(fwdb), 0);
    chk("rr_wb_wreg", 32'(wb_wreg), 0);
    chk("rr_count", 32'(stall_count), 0);
    step();

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      drive($urandom_range(0, 7), $urandom_range(0, 7),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
            $urandom_range(0, 7), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0));
      rst = 1'($urandom_range(0, 63) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
